ahb_in: RTL and testbench

- AHB-Lite slave that moves 32-bit words from an external producer (sensor/counter logic) into the M0 system.
- Incoming words pass through a valid/ready handshake into a small FIFO. Software reads them one word at a time through a memory-mapped data register.
- A status register and a control register complete the interface. Word accesses only, word-aligned base.

---
 rtl/ahb_in_pkg.sv | 39 +++
 rtl/ahb_in_sync_fifo.sv | 87 ++++++++
 rtl/ahb_in.sv | 154 +++++++++++++++
 tb/tb_ahb_in.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_in_pkg.sv
// Shared constants for the ahb_in AHB-Lite producer-to-FIFO slave: HTRANS codes,
// register offsets and STATUS/CTRL bit positions.
package ahb_in_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_UNDERFLOW = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_UFLOW = 1;

    // The count field is 8 bits wide in the word, so DEPTH is limited to 128.
    function automatic logic [31:0] status_word(
        input logic       not_empty,
        input logic       full,
        input logic       underflow,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                      = 32'h0000_0000;
        word[STAT_NOT_EMPTY]      = not_empty;
        word[STAT_FULL]           = full;
        word[STAT_UNDERFLOW]      = underflow;
        word[STAT_COUNT_LSB +: 8] = count;
        return word;
    endfunction

endpackage

// File: rtl/ahb_in_sync_fifo.sv
// Single-clock FIFO with combinational head output and a flush that overrides
// any push or pop on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next pointers and occupancy; power-of-two DEPTH lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ahb_in.sv
// AHB-Lite slave exposing a producer FIFO as DATA/STATUS/CTRL registers.
// Define AHB_IN_BLOCKING_READ_EN to stall empty DATA reads instead of flagging Underflow.
module ahb_in
    import ahb_in_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic [31:0] DataIn,
    input  logic        DataInValid,
    output logic        DataInReady
);

    logic             write_en_q;
    logic             write_en_d;
    logic             read_en_q;
    logic             read_en_d;
    logic [1:0]       addr_q;
    logic [1:0]       addr_d;
    logic             underflow_q;
    logic             underflow_d;

    logic [31:0]      head_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             hreadyout_s;
    logic             data_rd_s;
    logic             ctrl_wr_s;
    logic             pop_s;
    logic             flush_s;
    logic             clr_uflow_s;
    logic [31:0]      hrdata_s;
    logic             unused_s;

    assign unused_s = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:2]};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .push_i  (DataInValid),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .din_i   (DataIn),
        .dout_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign data_rd_s   = read_en_q && (addr_q == REG_DATA);
    assign ctrl_wr_s   = write_en_q && (addr_q == REG_CTRL) && hreadyout_s;
    assign pop_s       = data_rd_s && hreadyout_s && !empty_s;
    assign flush_s     = ctrl_wr_s && HWDATA[CTRL_FLUSH];
    assign clr_uflow_s = ctrl_wr_s && HWDATA[CTRL_CLR_UFLOW];

`ifdef AHB_IN_BLOCKING_READ_EN
    // Hold the bus while a DATA read waits for the producer.
    assign hreadyout_s = !(data_rd_s && empty_s);
`else
    assign hreadyout_s = 1'b1;
`endif

    assign HREADYOUT   = hreadyout_s;
    assign DataInReady = !full_s;
    assign HRDATA      = hrdata_s;

    // Address-phase capture; cleared for idle or unselected cycles.
    always_comb begin
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        addr_d     = 2'b00;
        if (HSEL && (HTRANS != HTRANS_IDLE)) begin
            write_en_d = HWRITE;
            read_en_d  = !HWRITE;
            addr_d     = HADDR[3:2];
        end else begin
            write_en_d = 1'b0;
            read_en_d  = 1'b0;
            addr_d     = 2'b00;
        end
    end

    // Sticky Underflow: set by an empty DATA read, cleared through CTRL.
    always_comb begin
        underflow_d = underflow_q;
`ifdef AHB_IN_BLOCKING_READ_EN
        if (clr_uflow_s) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
`else
        if (data_rd_s && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_uflow_s) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
`endif
    end

    // Read mux; anything outside an active read data phase returns zero.
    always_comb begin
        hrdata_s = 32'h0000_0000;
        if (read_en_q) begin
            case (addr_q)
                REG_DATA:   hrdata_s = empty_s ? 32'h0000_0000 : head_s;
                REG_STATUS: hrdata_s = status_word(!empty_s, full_s, underflow_q, 8'(count_s));
                default:    hrdata_s = 32'h0000_0000;
            endcase
        end else begin
            hrdata_s = 32'h0000_0000;
        end
    end

    // Control registers advance only while the bus is ready.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            write_en_q  <= 1'b0;
            read_en_q   <= 1'b0;
            addr_q      <= 2'b00;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            if (HREADY) begin
                write_en_q <= write_en_d;
                read_en_q  <= read_en_d;
                addr_q     <= addr_d;
            end else begin
                write_en_q <= write_en_q;
                read_en_q  <= read_en_q;
                addr_q     <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ahb_in.sv
// Self-checking bench for ahb_in: a vector table of bus/producer operations plus
// hand-written sequences for fill, flush-with-push and blocking-read stalls.
module tb_ahb_in;
    import ahb_in_pkg::*;

    localparam int DEPTH = 4;
    localparam int BOUND = 50;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [31:0] DataIn;
    logic        DataInValid;
    logic        DataInReady;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_PUSH} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    ahb_in #(.DEPTH(DEPTH)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HSIZE       (HSIZE),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HREADY      (HREADY),
        .HSEL        (HSEL),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady)
    );

    // Single-slave system: the bus ready is this slave's ready.
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input op_e op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp);
        vec_t v;
        v.op   = op;
        v.addr = addr;
        v.data = data;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        int waited;
        logic [31:0] e;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = addr;
        exp_q.push_back(exp);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0;
        waited = 0;
        while (!HREADYOUT && waited < BOUND) begin
            @(posedge HCLK); #1;
            waited++;
        end
        e = exp_q.pop_front();
        if (!HREADYOUT) check({name, "_timeout"}, {31'b0, HREADYOUT}, 32'h1);
        else            check(name, HRDATA, e);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic push_en, input logic [31:0] push_data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = 32'h0; HWDATA = data;
        if (push_en) begin
            DataIn = push_data;
            DataInValid = 1'b1;
        end
        @(posedge HCLK); #1;
        DataInValid = 1'b0;
        HWDATA = 32'h0;
    endtask

    task automatic push_word(input logic [31:0] d);
        int waited;
        @(posedge HCLK); #1;
        DataIn = d; DataInValid = 1'b1;
        waited = 0;
        while (!DataInReady && waited < BOUND) begin
            @(posedge HCLK); #1;
            waited++;
        end
        check("push_ready", {31'b0, DataInReady}, 32'h1);
        @(posedge HCLK); #1;
        DataInValid = 1'b0;
    endtask

    initial begin
        int acc;
        int lows;
        logic rdy;

        HRESET = 1'b1; HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0; HSEL = 1'b0; DataIn = 32'h0; DataInValid = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
        check("rst_datainready", {31'b0, DataInReady}, 32'h1);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESET = 1'b0;

        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0000);
        add_vec(OP_PUSH, 32'h0,         32'hA5A5_0001, 32'h0);
        add_vec(OP_PUSH, 32'h0,         32'hA5A5_0002, 32'h0);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0201);
        add_vec(OP_RD,   32'h0000_0000, 32'h0,         32'hA5A5_0001);
        add_vec(OP_RD,   32'h0000_0000, 32'h0,         32'hA5A5_0002);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0000);
`ifndef AHB_IN_BLOCKING_READ_EN
        add_vec(OP_RD,   32'h0000_0000, 32'h0,         32'h0000_0000);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0004);
        add_vec(OP_WR,   32'h0000_0008, 32'h0000_0002, 32'h0);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0000);
`endif
        add_vec(OP_WR,   32'h0000_0000, 32'h1234_5678, 32'h0);
        add_vec(OP_WR,   32'h0000_000C, 32'hFFFF_FFFF, 32'h0);
        add_vec(OP_PUSH, 32'h0,         32'h5555_AAAA, 32'h0);
        add_vec(OP_RD,   32'h0000_0008, 32'h0,         32'h0000_0000);
        add_vec(OP_RD,   32'h0000_000C, 32'h0,         32'h0000_0000);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0101);
        add_vec(OP_RD,   32'h0000_0000, 32'h0,         32'h5555_AAAA);
        add_vec(OP_RD,   32'h0000_0004, 32'h0,         32'h0000_0000);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RD:   ahb_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd", i));
                OP_WR:   ahb_write(vecs[i].addr, vecs[i].data, 1'b0, 32'h0);
                OP_PUSH: push_word(vecs[i].data);
                default: ;
            endcase
        end

        // Fill with DataInValid held high: exactly DEPTH words accepted.
        @(posedge HCLK); #1;
        DataIn = 32'hC0DE_0000; DataInValid = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            rdy = DataInReady;
            @(posedge HCLK); #1;
            if (rdy) begin
                acc++;
                DataIn = 32'hC0DE_0000 + 32'(acc);
            end
        end
        check("fill_accepted", 32'(acc), 32'd4);
        check("fill_ready_low", {31'b0, DataInReady}, 32'h0);
        ahb_read(32'h4, 32'h0000_0403, "fill_status");
        ahb_read(32'h0, 32'hC0DE_0000, "fill_head");
        check("ready_before_pop", {31'b0, DataInReady}, 32'h0);
        @(posedge HCLK); #1;
        check("ready_after_pop", {31'b0, DataInReady}, 32'h1);
        @(posedge HCLK); #1;
        DataInValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ahb_read(32'h0, 32'hC0DE_0000 + 32'(i), $sformatf("order_%0d", i));
        end
        ahb_read(32'h4, 32'h0, "drain_status");

        // Flush concurrent with a push: the pushed word is dropped.
        push_word(32'h0F0F_0001);
        push_word(32'h0F0F_0002);
        push_word(32'h0F0F_0003);
        ahb_read(32'h4, 32'h0000_0301, "preflush_status");
        ahb_write(32'h8, 32'h0000_0001, 1'b1, 32'hBAD0_0000);
        ahb_read(32'h4, 32'h0, "flush_status");
        push_word(32'h1111_2222);
        ahb_read(32'h0, 32'h1111_2222, "after_flush_data");
        ahb_read(32'h4, 32'h0, "after_flush_status");

`ifdef AHB_IN_BLOCKING_READ_EN
        // Empty DATA read stalls until a word arrives five cycles later.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            if (!HREADYOUT) lows++;
            if (i == 4) begin
                DataIn = 32'hDEAD_BEEF;
                DataInValid = 1'b1;
            end
            @(posedge HCLK); #1;
        end
        DataInValid = 1'b0;
        check("stall_cycles", 32'(lows), 32'd5);
        check("stall_release", {31'b0, HREADYOUT}, 32'h1);
        check("stall_data", HRDATA, 32'hDEAD_BEEF);
        @(posedge HCLK); #1;
        ahb_read(32'h4, 32'h0, "stall_status");

        // Reset in the middle of a stall releases the bus on that edge.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        @(posedge HCLK); #1;
        check("midstall_low", {31'b0, HREADYOUT}, 32'h0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        check("midstall_reset", {31'b0, HREADYOUT}, 32'h1);
        HRESET = 1'b0;
        ahb_read(32'h4, 32'h0, "no_underflow_status");
`else
        lows = 0;
        check("nb_lows", 32'(lows), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
